// File: rtl/sdram_pkg.sv
// Shared SDRAM controller types: access descriptor, data beat, row and port id.
package sdram_pkg;

  localparam int unsigned BANK_W    = 2;
  localparam int unsigned ROW_W     = 13;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned DATA_W    = 16;
  // Largest upstream port count the shared port id type must address.
  localparam int unsigned MAX_PORTS = 4;
  localparam int unsigned PORT_ID_W = (MAX_PORTS > 1) ? $clog2(MAX_PORTS) : 1;

  typedef logic [ROW_W-1:0]     row_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [PORT_ID_W-1:0] port_id_t;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    row_t              row;
    logic [COL_W-1:0]  col;
  } dram_access_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational winner select for the SDRAM arbiter.
// Macro SDRAM_ARB_FIXED_PRIO_EN: defined -> lowest requesting index wins;
// undefined -> round-robin starting strictly after last_idx.
module sdram_rr_pick
  import sdram_pkg::*;
#(
  parameter int unsigned N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] req,
  input  port_id_t           last_idx,
  output logic               valid_c,
  output port_id_t           idx_c
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_idx;

  // Lowest-index requester wins.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!valid_c && req[i]) begin
        valid_c = 1'b1;
        idx_c   = PORT_ID_W'(i);
      end
    end
  end
`else
  // Two passes: ports above last_idx first, then wrap to ports at or below it.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!valid_c && req[i] && (PORT_ID_W'(i) > last_idx)) begin
        valid_c = 1'b1;
        idx_c   = PORT_ID_W'(i);
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!valid_c && req[i] && (PORT_ID_W'(i) <= last_idx)) begin
        valid_c = 1'b1;
        idx_c   = PORT_ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Multiplexes N_PORTS request streams onto one command stream in bursts of
// up to N_BURSTS beats, and fans read returns back out by tag.
// Macro SDRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned N_PORTS  = 4,
  parameter int unsigned N_BURSTS = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_IN,
  input  logic         [N_PORTS-1:0] SRC_WRITE_IN,
  input  logic         [N_PORTS-1:0] SRC_RCHG_IN,
  input  logic         [N_PORTS-1:0] SRC_REQ_IN,
  input  dram_access_t [N_PORTS-1:0] SRC_ACS_IN,
  output logic         [N_PORTS-1:0] SRC_ACK_OUT,
  output data_t        [N_PORTS-1:0] SRC_DATA_OUT,
  output logic         [N_PORTS-1:0] SRC_RVALID_OUT,
  output logic                       CMD_WRITE_OUT,
  output logic                       CMD_RCHG_OUT,
  output logic                       CMD_REQ_OUT,
  output dram_access_t               CMD_ACS_OUT,
  output port_id_t                   CMD_TAG_OUT,
  input  logic                       CMD_ACK_IN,
  input  data_t                      CMD_DATA_IN,
  input  logic                       CMD_RVALID_IN,
  input  port_id_t                   CMD_RTAG_IN
);

  localparam int unsigned CNT_W = $clog2(N_BURSTS) + 1;

  arb_state_t         state_q, state_d;
  port_id_t           grant_q, grant_d;
  port_id_t           last_q,  last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  data_t [N_PORTS-1:0] rdata_q, rdata_d;
  logic [N_PORTS-1:0] rvalid_q, rvalid_d;

  logic               pick_valid;
  port_id_t           pick_idx;

  sdram_rr_pick #(
    .N_PORTS (N_PORTS)
  ) u_pick (
    .req      (SRC_REQ_IN),
    .last_idx (last_q),
    .valid_c  (pick_valid),
    .idx_c    (pick_idx)
  );

  // Arbitration state and burst bookkeeping registers.
  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PORT_ID_W'(N_PORTS - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Grant lock/release and the combinational pass-through of the granted port.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    count_d       = count_q;
    CMD_REQ_OUT   = 1'b0;
    CMD_WRITE_OUT = 1'b0;
    CMD_RCHG_OUT  = 1'b0;
    CMD_ACS_OUT   = '0;
    CMD_TAG_OUT   = grant_q;
    SRC_ACK_OUT   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          count_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        CMD_REQ_OUT          = SRC_REQ_IN[grant_q];
        CMD_WRITE_OUT        = SRC_WRITE_IN[grant_q];
        CMD_ACS_OUT          = SRC_ACS_IN[grant_q];
        // Open row is unknown after a port switch, so the first beat forces a row change.
        CMD_RCHG_OUT         = (count_q == '0) || SRC_RCHG_IN[grant_q];
        SRC_ACK_OUT[grant_q] = CMD_ACK_IN;
        if (!SRC_REQ_IN[grant_q]) begin
          state_d = IDLE;
        end else if (CMD_ACK_IN) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_BURSTS - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return fan-out, independent of the current grant.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rdata_d[p]  = CMD_DATA_IN;
      rvalid_d[p] = CMD_RVALID_IN && (CMD_RTAG_IN == PORT_ID_W'(p));
    end
  end

  // Read return registers (one cycle latency).
  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign SRC_DATA_OUT   = rdata_q;
  assign SRC_RVALID_OUT = rvalid_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized and directed bench for sdram_arbiter against a transaction-level model.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int N     = 4;
  localparam int NB    = 8;
  localparam int ACS_W = $bits(dram_access_t);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         src_write, src_rchg, src_req, src_ack, src_rvalid;
  dram_access_t [N-1:0] src_acs;
  data_t [N-1:0]        src_data;
  logic                 cmd_write, cmd_rchg, cmd_req, cmd_ack, cmd_rvalid;
  dram_access_t         cmd_acs;
  port_id_t             cmd_tag, cmd_rtag;
  data_t                cmd_data;

  int checks   = 0;
  int failures = 0;

  // Model: owner = port holding the bus (-1 = arbitration cycle), beats = transfers so far.
  int     m_owner, m_beats, m_last;
  logic [N-1:0] m_rvalid;
  data_t  m_rdata;
  int     grant_log[$];
  int     xfer_log[$];

  always #5 clk = ~clk;

  sdram_arbiter #(.N_PORTS(N), .N_BURSTS(NB)) dut (
    .CLK            (clk),
    .RESET_IN       (rst),
    .SRC_WRITE_IN   (src_write),
    .SRC_RCHG_IN    (src_rchg),
    .SRC_REQ_IN     (src_req),
    .SRC_ACS_IN     (src_acs),
    .SRC_ACK_OUT    (src_ack),
    .SRC_DATA_OUT   (src_data),
    .SRC_RVALID_OUT (src_rvalid),
    .CMD_WRITE_OUT  (cmd_write),
    .CMD_RCHG_OUT   (cmd_rchg),
    .CMD_REQ_OUT    (cmd_req),
    .CMD_ACS_OUT    (cmd_acs),
    .CMD_TAG_OUT    (cmd_tag),
    .CMD_ACK_IN     (cmd_ack),
    .CMD_DATA_IN    (cmd_data),
    .CMD_RVALID_IN  (cmd_rvalid),
    .CMD_RTAG_IN    (cmd_rtag)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int p = 0; p < N; p++) if (r[p]) return p;
`else
    for (int k = 1; k <= N; k++) if (r[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return -1;
  endfunction

  function automatic int glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int xlog(input int i);
    return (i < xfer_log.size()) ? xfer_log[i] : -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_beats  = 0;
    m_last   = N - 1;
    m_rvalid = '0;
    m_rdata  = '0;
  endtask

  task automatic check_outputs();
    logic         exp_req;
    logic [N-1:0] exp_ack;
    exp_req = (m_owner >= 0) && src_req[m_owner];
    exp_ack = '0;
    if (m_owner >= 0) exp_ack[m_owner] = cmd_ack;
    check_eq("cmd_req", 64'(cmd_req), 64'(exp_req));
    check_eq("src_ack", 64'(src_ack), 64'(exp_ack));
    if (m_owner >= 0) begin
      check_eq("cmd_tag",   64'(cmd_tag),   64'(m_owner));
      check_eq("cmd_acs",   64'(cmd_acs),   64'(src_acs[m_owner]));
      check_eq("cmd_write", 64'(cmd_write), 64'(src_write[m_owner]));
      check_eq("cmd_rchg",  64'(cmd_rchg),  64'((m_beats == 0) ? 1'b1 : src_rchg[m_owner]));
    end
    check_eq("src_rvalid", 64'(src_rvalid), 64'(m_rvalid));
    for (int p = 0; p < N; p++) check_eq("src_data", 64'(src_data[p]), 64'(m_rdata));
  endtask

  task automatic model_update();
    int w;
    for (int p = 0; p < N; p++) m_rvalid[p] = cmd_rvalid && (int'(cmd_rtag) == p);
    m_rdata = cmd_data;
    if (m_owner < 0) begin
      w = model_pick(src_req);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_beats = 0;
        grant_log.push_back(w);
        xfer_log.push_back(0);
      end
    end else if (!src_req[m_owner]) begin
      m_owner = -1;
    end else if (cmd_ack) begin
      m_beats++;
      xfer_log[xfer_log.size()-1] = xfer_log[xfer_log.size()-1] + 1;
      if (m_beats == NB) m_owner = -1;
    end
  endtask

  // One clock: check outputs at negedge, advance model at posedge, return just after it.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_cmd_req", 64'(cmd_req), 64'(0));
    check_eq("rst_src_ack", 64'(src_ack), 64'(0));
    cycle();
    cycle();
    rst = 1'b0;
    grant_log.delete();
    xfer_log.delete();
  endtask

  task automatic quiet_inputs();
    src_write  = '0;
    src_rchg   = '0;
    src_req    = '0;
    src_acs    = '0;
    cmd_ack    = 1'b0;
    cmd_data   = '0;
    cmd_rvalid = 1'b0;
    cmd_rtag   = '0;
  endtask

  initial begin
    int exp_seq[5];
    quiet_inputs();
    rst = 1'b1;
    do_reset();

    // Single port steady request with ack always high.
    src_req = 4'b0100;
    cmd_ack = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    check_eq("s1_grant", 64'(glog(0)), 64'(2));
    check_eq("s1_beats", 64'(xlog(0)), 64'(NB));
    check_eq("s1_regrant", 64'(glog(1)), 64'(2));

    // All ports requesting continuously.
    quiet_inputs();
    do_reset();
    src_req = 4'b1111;
    cmd_ack = 1'b1;
    for (int i = 0; i < 46; i++) cycle();
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) check_eq("s2_grant_seq", 64'(glog(i)), 64'(exp_seq[i]));
    for (int i = 0; i < 4; i++) check_eq("s2_beats", 64'(xlog(i)), 64'(NB));

    // Port 1 drops its request after three beats.
    quiet_inputs();
    do_reset();
    src_req = 4'b0110;
    cmd_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_owner == 1 && m_beats == 3) src_req[1] = 1'b0;
    end
    check_eq("s3_first", 64'(glog(0)), 64'(1));
    check_eq("s3_short_beats", 64'(xlog(0)), 64'(3));
    check_eq("s3_second", 64'(glog(1)), 64'(2));
    check_eq("s3_full_beats", 64'(xlog(1)), 64'(NB));

    // Sequencer ack toggling during a grant.
    quiet_inputs();
    do_reset();
    src_req = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      cmd_ack = ~cmd_ack;
      cycle();
    end
    check_eq("s4_beats", 64'(xlog(0)), 64'(NB));

    // Read return for port 3 while port 0 holds the grant.
    quiet_inputs();
    do_reset();
    src_req = 4'b0001;
    cmd_ack = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    cmd_rvalid = 1'b1;
    cmd_rtag   = 2'd3;
    cmd_data   = 16'hA5A5;
    cycle();
    check_eq("s5_rvalid", 64'(src_rvalid), 64'(4'b1000));
    check_eq("s5_rdata", 64'(src_data[3]), 64'(16'hA5A5));
    check_eq("s5_owner_tag", 64'(cmd_tag), 64'(0));
    cmd_rvalid = 1'b0;
    cycle();

    // Reset in the middle of a burst.
    quiet_inputs();
    do_reset();
    src_req = 4'b0001;
    cmd_ack = 1'b1;
    for (int i = 0; i < 20 && !(m_owner == 0 && m_beats == 4); i++) cycle();
    check_eq("s6_reached_beat4", 64'(m_beats), 64'(4));
    src_req = 4'b1111;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    check_eq("s6_first_after_rst", 64'(glog(0)), 64'(0));

    // Randomized traffic with occasional resets.
    quiet_inputs();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 7) == 0) src_req[p] = ~src_req[p];
        src_write[p] = 1'($urandom);
        src_rchg[p]  = 1'($urandom);
        src_acs[p]   = dram_access_t'(ACS_W'($urandom));
      end
      cmd_ack    = ($urandom_range(0, 3) != 0);
      cmd_rvalid = 1'($urandom);
      cmd_rtag   = port_id_t'(PORT_ID_W'($urandom));
      cmd_data   = data_t'(DATA_W'($urandom));
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: SDRAM_ARBITER

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of upstream request streams.
REQ-002 SHALL have parameter N_BURSTS, default 8: maximum beats per grant.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET_IN  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports SRC_WRITE_IN, SRC_RCHG_IN, SRC_REQ_IN  input  [N_PORTS]  per-port write flag, row-change flag and request, from the per-port FIFO stage.
REQ-006 SHALL have port SRC_ACS_IN  input  [N_PORTS] x dram_access_t  per-port access (bank/row/column).
REQ-007 SHALL have port SRC_ACK_OUT  output  [N_PORTS]  per-port accept.
REQ-008 SHALL have ports SRC_DATA_OUT  output  [N_PORTS] x data_t  and SRC_RVALID_OUT  output  [N_PORTS]  returned read data and per-port valid.
REQ-009 SHALL have ports CMD_WRITE_OUT, CMD_RCHG_OUT, CMD_REQ_OUT  output  1, CMD_ACS_OUT  output  dram_access_t, CMD_TAG_OUT  output  port_id_t  single stream to the command sequencer.
REQ-010 SHALL have port CMD_ACK_IN  input  1  sequencer accept.
REQ-011 SHALL have ports CMD_DATA_IN  input  data_t, CMD_RVALID_IN  input  1, CMD_RTAG_IN  input  port_id_t  read return with originating port.

Function
REQ-012 Beat transfer SHALL occur on a cycle with CMD_REQ_OUT=1 and CMD_ACK_IN=1.
REQ-013 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-014 In IDLE, CMD_REQ_OUT=0 and SRC_ACK_OUT=0; if any SRC_REQ_IN is set, the winner SHALL be registered into grant g, the beat count zeroed, and the FSM SHALL move to GRANT; first CMD_REQ_OUT is one cycle after the request is seen.
REQ-015 Round-robin: winner SHALL be the first requesting port strictly after the last granted port, wrapping N_PORTS-1 -> 0.
REQ-016 In GRANT, CMD_REQ_OUT, CMD_WRITE_OUT, CMD_ACS_OUT SHALL combinationally equal port g's inputs; CMD_TAG_OUT=g; SRC_ACK_OUT[g]=CMD_ACK_IN; all other SRC_ACK_OUT bits 0.
REQ-017 CMD_RCHG_OUT SHALL be forced to 1 on the first beat of every grant (open row unknown after a port switch), otherwise SRC_RCHG_IN[g].
REQ-018 Beat count SHALL increment per transfer; on the transfer with count=N_BURSTS-1 the FSM SHALL return to IDLE.
REQ-019 If SRC_REQ_IN[g]=0 in GRANT, the FSM SHALL return to IDLE next cycle (no transfer that cycle).
REQ-020 Release and new request in the same cycle: the new request SHALL be arbitrated in the following IDLE cycle; no cycle may grant two ports.
REQ-021 Read return SHALL be registered, 1-cycle latency: SRC_DATA_OUT[p] <= CMD_DATA_IN for every p; SRC_RVALID_OUT[p] <= CMD_RVALID_IN and CMD_RTAG_IN=p.
REQ-022 Read return SHALL be independent of FSM state and grant (returns may overlap other grants).
REQ-023 Beat counter width SHALL be $clog2(N_BURSTS)+1 bits; port_id_t width max(1,$clog2(N_PORTS)).

Reset
REQ-024 On RESET_IN: FSM=IDLE, g=0, last-granted=N_PORTS-1 (port 0 wins first), count=0, SRC_RVALID_OUT=0, SRC_DATA_OUT=0; CMD_REQ_OUT and SRC_ACK_OUT thus 0.
REQ-025 Reset mid-burst SHALL abort the grant immediately; no further beat of that burst is issued.

Configuration
REQ-026 Macro SDRAM_ARB_FIXED_PRIO_EN: defined -> winner is lowest-index requesting port (last-granted ignored); undefined -> round-robin per REQ-015. Grant lock/release identical in both.

Structure
REQ-027 port_id_t SHALL be added to SDRAM_PKG beside dram_access_t, data_t, row_t; no local redefinition.
REQ-028 Winner selection SHALL be one combinational sub-module SDRAM_RR_PICK (request vector, last index -> valid, index).

Verification
REQ-029 Reset, port 2 REQ steady, CMD_ACK_IN=1 -> CMD_REQ_OUT rises 1 cycle later, 8 beats, tag=2, CMD_RCHG_OUT=1 on beat 0 only, then one IDLE cycle.
REQ-030 All 4 ports requesting continuously -> grants 0,1,2,3,0 each 8 beats; fixed-prio build -> port 0 every grant.
REQ-031 Port 1 drops REQ after 3 beats -> IDLE next cycle, port 2 granted after; count restarts at 0.
REQ-032 CMD_ACK_IN toggling 1/0 during grant -> exactly 8 transfers, SRC_ACK_OUT only on granted bit, aligned to CMD_ACK_IN.
REQ-033 CMD_RVALID_IN=1, CMD_RTAG_IN=3, data 0xA5A5 while port 0 granted -> next cycle SRC_RVALID_OUT=4'b1000, SRC_DATA_OUT[3]=0xA5A5.
REQ-034 RESET_IN asserted at beat 4 -> CMD_REQ_OUT=0 immediately; after release port 0 wins first.
